// File: rtl/pwm_multi.sv
// Multi-channel PWM generator: shared prescaler and period counter, double-buffered duty per channel.
// Optional macro PWM_FADE_EN: at each period boundary, active duty steps by 1 toward shadow.
module pwm_multi #(
    parameter int CH       = 4,
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 1,
    localparam int CHW     = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             wr_en,
    input  logic [CHW-1:0]   wr_ch,
    input  logic [WIDTH-1:0] wr_data,
    output logic             period_start,
    output logic [CH-1:0]    led
);

    localparam int MAX = (1 << WIDTH) - 1;
    localparam int PW  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0]    presc, presc_next;
    logic [WIDTH-1:0] cnt, cnt_next;
    logic             en_q, run, tick, boundary, wr_ok;
    logic [WIDTH-1:0] shadow      [CH];
    logic [WIDTH-1:0] active      [CH];
    logic [WIDTH-1:0] shadow_next [CH];
    logic [WIDTH-1:0] active_next [CH];
    logic [CH-1:0]    led_next;

    // The counters only advance once en has been high for a cycle, so the first
    // period after enabling spends its full first tick at cnt=0.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        run      = en & en_q;
        tick     = run && (presc == PW'(PRESCALE - 1));
        boundary = tick && (cnt == WIDTH'(MAX - 1));
        wr_ok    = wr_en && (32'(wr_ch) < CH);

        presc_next = presc + PW'(1);
        if (!run || tick)
            presc_next = '0;

        cnt_next = cnt;
        if (!run || boundary)
            cnt_next = '0;
        else if (tick)
            cnt_next = cnt + WIDTH'(1);

        for (int i = 0; i < CH; i++) begin
            shadow_next[i] = shadow[i];
            if (wr_ok && wr_ch == CHW'(i))
                shadow_next[i] = wr_data;

            active_next[i] = active[i];
            if (!run) begin
                active_next[i] = shadow_next[i];
            end else if (boundary) begin
`ifdef PWM_FADE_EN
                // Fading steps toward the pre-write shadow, so boundary writes are not bypassed.
                if (active[i] < shadow[i])
                    active_next[i] = active[i] + WIDTH'(1);
                else if (active[i] > shadow[i])
                    active_next[i] = active[i] - WIDTH'(1);
`else
                active_next[i] = shadow_next[i];
`endif
            end

            led_next[i] = en && (cnt_next < active_next[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc        <= '0;
            cnt          <= '0;
            en_q         <= 1'b0;
            period_start <= 1'b0;
            led          <= '0;
            // NOTE: the duty arrays are small register banks and must read zero after reset, so they are reset here.
            for (int i = 0; i < CH; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            presc        <= presc_next;
            cnt          <= cnt_next;
            en_q         <= en;
            period_start <= boundary;
            led          <= led_next;
            for (int i = 0; i < CH; i++) begin
                shadow[i] <= shadow_next[i];
                active[i] <= active_next[i];
            end
        end
    end

endmodule

// File: tb/tb_pwm_multi.sv
// Self-checking bench for pwm_multi: two instances (CH=4/PRESCALE=1 and CH=6/PRESCALE=4) against a time-based reference model.
module tb_pwm_multi;

    localparam int MAXV = 255;
    localparam int NCH [2] = '{4, 6};
    localparam int NP  [2] = '{1, 4};

    logic       clk, rst, en;
    logic       wr_en_a, wr_en_b;
    logic [1:0] wr_ch_a;
    logic [2:0] wr_ch_b;
    logic [7:0] wr_data_a, wr_data_b;
    logic       ps_a, ps_b;
    logic [3:0] led_a;
    logic [5:0] led_b;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference model: m_t is the clock count since the current period began.
    int          m_shadow [2][16];
    int          m_active [2][16];
    int          m_t      [2];
    bit          m_prev   [2];
    logic [15:0] m_led    [2];
    logic        m_ps     [2];

    pwm_multi #(.CH(4), .WIDTH(8), .PRESCALE(1)) dut_a (
        .clk(clk), .rst(rst), .en(en), .wr_en(wr_en_a), .wr_ch(wr_ch_a),
        .wr_data(wr_data_a), .period_start(ps_a), .led(led_a)
    );

    pwm_multi #(.CH(6), .WIDTH(8), .PRESCALE(4)) dut_b (
        .clk(clk), .rst(rst), .en(en), .wr_en(wr_en_b), .wr_ch(wr_ch_b),
        .wr_data(wr_data_b), .period_start(ps_b), .led(led_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_t[k]    = 0;
            m_prev[k] = 1'b0;
            m_led[k]  = '0;
            m_ps[k]   = 1'b0;
            for (int i = 0; i < 16; i++) begin
                m_shadow[k][i] = 0;
                m_active[k][i] = 0;
            end
        end
    endtask

    task automatic model_step(input int k, input bit e, input bit we, input int wc, input int wd);
        int old_sh [16];
        for (int i = 0; i < 16; i++) old_sh[i] = m_shadow[k][i];
        if (we && wc < NCH[k]) m_shadow[k][wc] = wd;
        m_ps[k] = 1'b0;
        if (!e || !m_prev[k]) begin
            m_t[k]    = 0;
            m_prev[k] = e;
            for (int i = 0; i < 16; i++) m_active[k][i] = m_shadow[k][i];
        end else begin
            m_t[k]++;
            if (m_t[k] == MAXV * NP[k]) begin
                m_t[k]  = 0;
                m_ps[k] = 1'b1;
                for (int i = 0; i < 16; i++) begin
`ifdef PWM_FADE_EN
                    if (m_active[k][i] < old_sh[i]) m_active[k][i]++;
                    else if (m_active[k][i] > old_sh[i]) m_active[k][i]--;
`else
                    m_active[k][i] = m_shadow[k][i];
`endif
                end
            end
        end
        m_led[k] = '0;
        for (int i = 0; i < NCH[k]; i++)
            m_led[k][i] = e && ((m_t[k] / NP[k]) < m_active[k][i]);
    endtask

    // One clock: update the model with the inputs seen at the edge, then compare just after it.
    task automatic cycle();
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            model_step(0, en, wr_en_a, int'(wr_ch_a), int'(wr_data_a));
            model_step(1, en, wr_en_b, int'(wr_ch_b), int'(wr_data_b));
        end
        #1;
        check("led_a", 32'(led_a), 32'(m_led[0]));
        check("ps_a",  32'(ps_a),  32'(m_ps[0]));
        check("led_b", 32'(led_b), 32'(m_led[1]));
        check("ps_b",  32'(ps_b),  32'(m_ps[1]));
    endtask

    task automatic set_a(input int ch, input int data);
        wr_en_a = 1'b1; wr_ch_a = 2'(ch); wr_data_a = 8'(data);
        cycle();
        wr_en_a = 1'b0;
    endtask

    task automatic set_b(input int ch, input int data);
        wr_en_b = 1'b1; wr_ch_b = 3'(ch); wr_data_b = 8'(data);
        cycle();
        wr_en_b = 1'b0;
    endtask

    task automatic wait_ps(input int k);
        int n = 0;
        while ((((k == 0) ? ps_a : ps_b) !== 1'b1) && n < 3000) begin
            cycle();
            n++;
        end
        check((k == 0) ? "wait_ps_a" : "wait_ps_b", 32'((k == 0) ? ps_a : ps_b), 32'd1);
    endtask

    initial begin
        int hi, hi2;
        rst = 1'b1; en = 1'b0;
        wr_en_a = 1'b0; wr_ch_a = '0; wr_data_a = '0;
        wr_en_b = 1'b0; wr_ch_b = '0; wr_data_b = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_led_a", 32'(led_a), 32'd0);
        check("reset_ps_a",  32'(ps_a),  32'd0);
        check("reset_led_b", 32'(led_b), 32'd0);
        check("reset_ps_b",  32'(ps_b),  32'd0);
        rst = 1'b0;

        // Basic duty on ch0; two full periods measured explicitly.
        en = 1'b1;
        set_a(0, 97);
        set_b(0, 97);
        wait_ps(0);
        for (int p = 0; p < 2; p++) begin
            hi = 0;
            for (int c = 0; c < 255; c++) begin
                hi += int'(led_a[0]);
                cycle();
            end
            check("ch0_97_high", 32'(hi), 32'd97);
            check("ch0_97_period", 32'(ps_a), 32'd1);
        end

        // Duty extremes on A; out-of-range channel writes on B.
        set_a(1, 0);
        set_a(2, 255);
        set_b(7, 200);
        set_b(6, 55);
        wait_ps(0);
        hi = 0; hi2 = 0;
        for (int c = 0; c < 3 * 255; c++) begin
            hi  += int'(led_a[1]);
            hi2 += int'(led_a[2]);
            cycle();
        end
        check("duty0_high", 32'(hi), 32'd0);
        check("dutymax_high", 32'(hi2), 32'd765);
        check("b_oob_ignored", 32'(led_b[5:1]), 32'd0);

        // Mid-period write takes effect only from the next period.
        set_a(1, 50);
        wait_ps(0);
        hi = 0;
        for (int c = 0; c < 255; c++) begin
            hi += int'(led_a[1]);
            if (c == 100) begin
                wr_en_a = 1'b1; wr_ch_a = 2'd1; wr_data_a = 8'd200;
            end
            cycle();
            wr_en_a = 1'b0;
        end
        check("midwrite_old", 32'(hi), 32'd50);
        hi = 0;
        for (int c = 0; c < 255; c++) begin
            hi += int'(led_a[1]);
            cycle();
        end
        check("midwrite_new", 32'(hi), 32'd200);

        // Boundary-cycle write bypasses into the period starting (PRESCALE=1).
        repeat (254) cycle();
        set_a(0, 10);
        check("bnd_ps_a", 32'(ps_a), 32'd1);
        hi = 0;
        for (int c = 0; c < 255; c++) begin
            hi += int'(led_a[0]);
            cycle();
        end
        check("bnd_bypass_a", 32'(hi), 32'd10);

        // Same with PRESCALE=4: 40 clk high, 1020 clk period.
        wait_ps(1);
        repeat (1019) cycle();
        set_b(0, 10);
        check("bnd_ps_b", 32'(ps_b), 32'd1);
        hi = 0;
        for (int c = 0; c < 1020; c++) begin
            hi += int'(led_b[0]);
            cycle();
        end
        check("bnd_bypass_b", 32'(hi), 32'd40);
        check("period_b_1020", 32'(ps_b), 32'd1);

        // Asynchronous reset mid-period.
        set_a(0, 200);
        wait_ps(0);
        repeat (120) cycle();
        check("pre_rst_led0", 32'(led_a[0]), 32'd1);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check("async_rst_led_a", 32'(led_a), 32'd0);
        check("async_rst_ps_a",  32'(ps_a),  32'd0);
        check("async_rst_led_b", 32'(led_b), 32'd0);
        cycle();
        rst = 1'b0;
        repeat (600) cycle();
        check("post_rst_idle", 32'(led_a), 32'd0);

        // Enable low mid-period, write during the low time, then re-enable.
        set_a(0, 30);
        repeat (100) cycle();
        en = 1'b0;
        repeat (150) cycle();
        set_a(0, 60);
        repeat (149) cycle();
        check("en_low_led", 32'(led_a), 32'd0);
        en = 1'b1;
        hi = 0;
        for (int c = 0; c < 255; c++) begin
            cycle();
            hi += int'(led_a[0]);
        end
        check("reenable_high", 32'(hi), 32'd60);
        cycle();
        check("reenable_first_wrap", 32'(ps_a), 32'd1);

        // Randomised writes and enable toggles against the model.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 299) == 0) en = ~en;
            wr_en_a   = ($urandom_range(0, 7) == 0);
            wr_ch_a   = 2'($urandom_range(0, 3));
            wr_data_a = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? 8'd0 : 8'd255)
                                                    : 8'($urandom);
            wr_en_b   = ($urandom_range(0, 7) == 0);
            wr_ch_b   = 3'($urandom_range(0, 7));
            wr_data_b = 8'($urandom);
            cycle();
        end
        wr_en_a = 1'b0;
        wr_en_b = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
